cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter N, default `N: number of CDB lanes, i.e. the maximum broadcasts per cycle.
REQ-003 Parameter NUM_REQ, default `NUM_FU_TOTAL: number of FU result requesters.
REQ-004 Ports SHALL be:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, asserted when 0.
- fu_valid  in  NUM_REQ  requester i presents a completed result.
- fu_result  in  FU_RESULT_PACKET[NUM_REQ]  reg_idx, value, b_mask per requester.
- br_id  in  BR_MASK  one-hot branch being resolved.
- br_task  in  BR_TASK  NOTHING/CLEAR/SQUASH.
- fu_ready  out  NUM_REQ  requester i result is accepted this cycle.
- cdb_out  out  CDB_PACKET[N]  broadcast lanes (valid, reg_idx, value).
- num_pending  out  $clog2(NUM_REQ+1)  count of occupied holding slots.

Function
REQ-005 The block SHALL keep exactly one holding slot per requester: a valid bit plus a FU_RESULT_PACKET.
REQ-006 fu_ready[i] SHALL equal !slot_valid[i] | granted[i] | squashed[i], combinationally in the same cycle.
REQ-007 Capture condition: fu_valid[i] & fu_ready[i] & no squash of the incoming result → slot loads at the next edge.
- Minimum capture-to-broadcast latency is 1 cycle.
REQ-008 Request vector SHALL be slot_valid & ~squash_hit.
- squash_hit[i] = (br_task==SQUASH) & |(slot.b_mask & br_id).
REQ-009 Each cycle the block SHALL grant up to min(N, requests) slots, in rotating priority starting at rr_ptr and wrapping modulo NUM_REQ.
REQ-010 Grants SHALL be packed into cdb_out lanes 0..k-1 in priority order.
- Lanes k..N-1: valid=0, other fields 0.
- cdb_out is combinational from slot state.
REQ-011 A granted slot SHALL be freed at the next edge unless it recaptures in the same cycle (back-to-back pass-through).
REQ-012 rr_ptr update on each edge:
- With at least one grant: rr_ptr ← (index of last granted requester + 1) mod NUM_REQ.
- With no grant: rr_ptr unchanged.
REQ-013 SQUASH handling:
- Slots with matching b_mask SHALL be invalidated at the edge and never broadcast.
- An incoming fu_result with matching b_mask SHALL be dropped, with fu_ready still 1.
REQ-014 CLEAR SHALL clear the br_id bit of every held slot b_mask and of any incoming captured b_mask.
REQ-015 num_pending SHALL equal the popcount of slot_valid, registered (it reflects current state).
REQ-016 A requester SHALL never be starved: a continuously valid slot is granted within ceil(NUM_REQ/N) cycles.

Reset
REQ-017 While reset==0 at an edge, the block SHALL:
- clear all slot_valid bits;
- set rr_ptr=0;
- zero all slot contents.
REQ-018 After reset the outputs SHALL be:
- cdb_out all zero (all lanes valid=0);
- fu_ready all 1;
- num_pending 0.
- Pending results are discarded, including in-flight results present during reset.

Structure
REQ-019 FU_RESULT_PACKET, CDB_PACKET, BR_MASK, BR_TASK and `NUM_FU_TOTAL (sum of `NUM_FU_ALU/MULT/LD/STORE/BR) SHALL reside in sys_defs.svh.
REQ-020 Rotating N-of-NUM_REQ selection SHALL be a single sub-module rr_psel, with:
- inputs: req, ptr;
- outputs: gnt_bus[N][NUM_REQ], gnt.
REQ-021 The block SHALL have no other sub-modules.
- Slot, pointer and mask-update logic are one always_comb plus one always_ff.

Verification (N=2, NUM_REQ=4)
REQ-022 Burst, from reset with fu_valid=1111 for one cycle:
- cycle+1: cdb lanes = req0, req1; fu_ready=0011.
- cycle+2: lanes = req2, req3.
- num_pending goes 4→2→0.
REQ-023 Fairness, with fu_valid=1111 held:
- grants alternate {0,1}, {2,3} every cycle;
- every requester broadcasts once per 2 cycles;
- pass-through holds with no bubble.
REQ-024 Squash, with slot2 b_mask=0010, then br_task=SQUASH, br_id=0010:
- slot2 is never on the CDB;
- fu_ready[2]=1 that cycle;
- num_pending decrements by one.
REQ-025 Clear, with slot1 b_mask=0110 blocked behind grants, then CLEAR br_id=0010, then SQUASH br_id=0010:
- slot1 survives and broadcasts later.
REQ-026 Reset mid-operation, with num_pending=3 and reset=0 for one edge:
- next cycle num_pending=0, all cdb_out valid=0, rr_ptr=0.
- First post-reset grant is req0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: result/broadcast packets, branch masks and tasks.
// Pure declarations, no logic; no latency.
// No flow control of its own.
package cdb_arbiter_pkg;

  localparam int NUM_FU_ALU   = 1;
  localparam int NUM_FU_MULT  = 1;
  localparam int NUM_FU_LD    = 1;
  localparam int NUM_FU_STORE = 0;
  localparam int NUM_FU_BR    = 1;
  localparam int NUM_FU_TOTAL = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LD + NUM_FU_STORE + NUM_FU_BR;

  localparam int CDB_N     = 2;
  localparam int BR_W      = 4;
  localparam int REG_IDX_W = 6;
  localparam int XLEN      = 32;

  typedef logic [BR_W-1:0] br_mask_t;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } br_task_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [XLEN-1:0]      value;
    br_mask_t             b_mask;
  } fu_result_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [XLEN-1:0]      value;
  } cdb_packet_t;

  // True when a result depends on any branch named in br.
  function automatic logic mask_hit(input br_mask_t mask, input br_mask_t br);
    return |(mask & br);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_psel.sv
// Rotating-priority N-of-NUM_REQ selector: picks up to N requests starting at ptr, wrapping.
// Purely combinational, zero latency.
// No backpressure; ungranted requests simply stay asserted upstream.
module rr_psel #(
  parameter int N       = 2,
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_bus [N],
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] remaining;
  logic [PW-1:0]      idx;
  logic               found;

  // Lane l takes the first still-unclaimed request in rotated order from ptr.
  always_comb begin
    gnt       = '0;
    remaining = req;
    idx       = '0;
    found     = 1'b0;
    for (int l = 0; l < N; l++) begin
      gnt_bus[l] = '0;
      found      = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = PW'((int'(ptr) + k) % NUM_REQ);
        if (!found && remaining[idx]) begin
          found          = 1'b1;
          gnt_bus[l][idx] = 1'b1;
          gnt[idx]       = 1'b1;
          remaining[idx] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per FU, up to N round-robin broadcasts per cycle.
// Capture-to-broadcast 1 cycle; cdb_out is combinational from slot state.
// fu_ready drops only while a slot is held and neither granted nor squashed this cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N       = CDB_N,
  parameter int NUM_REQ = NUM_FU_TOTAL
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             fu_valid,
  input  fu_result_packet_t              fu_result [NUM_REQ],
  input  br_mask_t                       br_id,
  input  br_task_t                       br_task,
  output logic [NUM_REQ-1:0]             fu_ready,
  output cdb_packet_t                    cdb_out [N],
  output logic [$clog2(NUM_REQ+1)-1:0]   num_pending
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  fu_result_packet_t  slot_q [NUM_REQ];
  fu_result_packet_t  slot_d [NUM_REQ];
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      num_pending_q, num_pending_d;

  logic [NUM_REQ-1:0] squash_hit;
  logic [NUM_REQ-1:0] in_squash;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] gnt_bus [N];

  // Held results killed by a resolving mispredict never compete for a lane.
  always_comb begin
    squash_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      squash_hit[i] = (br_task == SQUASH) && mask_hit(slot_q[i].b_mask, br_id);
    end
    req = slot_valid_q & ~squash_hit;
  end

  rr_psel #(
    .N       (N),
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_psel (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_bus (gnt_bus),
    .gnt     (gnt)
  );

  // Slot refill/free, mask maintenance, lane packing and pointer advance.
  always_comb begin
    fu_ready     = ~slot_valid_q | gnt | squash_hit;
    slot_valid_d = slot_valid_q & ~(gnt | squash_hit);
    rr_ptr_d     = rr_ptr_q;
    in_squash    = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      if (br_task == CLEAR) begin
        slot_d[i].b_mask = slot_q[i].b_mask & ~br_id;
      end
      // A squashed incoming result is still acked so the FU can move on.
      in_squash[i] = (br_task == SQUASH) && mask_hit(fu_result[i].b_mask, br_id);
      if (fu_valid[i] && fu_ready[i] && !in_squash[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_d[i]       = fu_result[i];
        if (br_task == CLEAR) begin
          slot_d[i].b_mask = fu_result[i].b_mask & ~br_id;
        end
      end
    end

    // Lanes are filled in priority order, so the highest filled lane holds the
    // last granted requester and the pointer moves just past it.
    for (int l = 0; l < N; l++) begin
      cdb_out[l] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_bus[l][i]) begin
          cdb_out[l].valid   = 1'b1;
          cdb_out[l].reg_idx = slot_q[i].reg_idx;
          cdb_out[l].value   = slot_q[i].value;
          rr_ptr_d           = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
        end
      end
    end

    num_pending_d = CW'($countones(slot_valid_d));
  end

  // State registers; reset discards everything held, including in-flight captures.
  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_valid_q  <= '0;
      rr_ptr_q      <= '0;
      num_pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_valid_q  <= slot_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      num_pending_q <= num_pending_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign num_pending = num_pending_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (N=2, NUM_REQ=4): directed scenarios plus random traffic.
// Random traffic is checked against a queue-based model of the broadcast rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int NR = 4;
  localparam int CW = $clog2(NR + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     fu_valid;
  fu_result_packet_t fu_result [NR];
  br_mask_t          br_id;
  br_task_t          br_task;
  logic [NR-1:0]     fu_ready;
  cdb_packet_t       cdb_out [N];
  logic [CW-1:0]     num_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clock       (clock),
    .reset       (reset),
    .fu_valid    (fu_valid),
    .fu_result   (fu_result),
    .br_id       (br_id),
    .br_task     (br_task),
    .fu_ready    (fu_ready),
    .cdb_out     (cdb_out),
    .num_pending (num_pending)
  );

  // ---------------- reference model ----------------
  bit                m_valid [NR];
  fu_result_packet_t m_pkt [NR];
  int                m_ptr;
  cdb_packet_t       e_lanes [N];
  int                e_idx [N];
  bit                e_gnt [NR];
  bit                e_sq [NR];
  logic [NR-1:0]     e_ready;
  int                e_pending;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_pkt[i]   = '0;
    end
    m_ptr = 0;
  endtask

  task automatic model_predict();
    int order[$];
    e_pending = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_valid[i]) e_pending++;
      e_sq[i]  = m_valid[i] && (br_task == SQUASH) && ((m_pkt[i].b_mask & br_id) != 0);
      e_gnt[i] = 1'b0;
    end
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (m_valid[i] && !e_sq[i]) order.push_back(i);
    end
    for (int l = 0; l < N; l++) begin
      e_lanes[l] = '0;
      e_idx[l]   = -1;
      if (l < order.size()) begin
        e_idx[l]           = order[l];
        e_lanes[l].valid   = 1'b1;
        e_lanes[l].reg_idx = m_pkt[order[l]].reg_idx;
        e_lanes[l].value   = m_pkt[order[l]].value;
        e_gnt[order[l]]    = 1'b1;
      end
    end
    for (int i = 0; i < NR; i++) e_ready[i] = !m_valid[i] || e_gnt[i] || e_sq[i];
  endtask

  task automatic model_commit();
    int last;
    last = -1;
    for (int l = 0; l < N; l++) if (e_idx[l] >= 0) last = e_idx[l];
    for (int i = 0; i < NR; i++) begin
      if (e_gnt[i] || e_sq[i]) m_valid[i] = 1'b0;
      if (br_task == CLEAR) m_pkt[i].b_mask = m_pkt[i].b_mask & ~br_id;
      if (fu_valid[i] && e_ready[i] &&
          !((br_task == SQUASH) && ((fu_result[i].b_mask & br_id) != 0))) begin
        m_valid[i] = 1'b1;
        m_pkt[i]   = fu_result[i];
        if (br_task == CLEAR) m_pkt[i].b_mask = fu_result[i].b_mask & ~br_id;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % NR;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic fu_result_packet_t mk(input int i, input br_mask_t mask);
    fu_result_packet_t p;
    p.reg_idx = REG_IDX_W'(i + 1);
    p.value   = 32'hC0DE_0000 + 32'(i);
    p.b_mask  = mask;
    return p;
  endfunction

  function automatic cdb_packet_t exp_lane(input int i);
    cdb_packet_t c;
    c.valid   = 1'b1;
    c.reg_idx = REG_IDX_W'(i + 1);
    c.value   = 32'hC0DE_0000 + 32'(i);
    return c;
  endfunction

  task automatic set_idle();
    fu_valid = '0;
    br_task  = NOTHING;
    br_id    = '0;
    for (int i = 0; i < NR; i++) fu_result[i] = mk(i, 4'b0000);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    fu_valid = 4'b1111;
    reset    = 1'b0;
    tick();
    tick();
    reset    = 1'b1;
    fu_valid = 4'b0000;
    #1;
    for (int l = 0; l < N; l++) begin
      n_cmp++;
      if (cdb_out[l] !== cdb_packet_t'(0)) begin
        n_bad++; $display("FAIL reset_lane%0d: got %h want 0", l, cdb_out[l]);
      end
    end
    n_cmp++;
    if (fu_ready !== 4'b1111) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", fu_ready); end
    n_cmp++;
    if (num_pending !== 3'd0) begin n_bad++; $display("FAIL reset_pending: got %0d want 0", num_pending); end
  endtask

  task automatic test_burst();
    do_reset();
    fu_valid = 4'b1111;
    tick();
    set_idle();
    #1;
    n_cmp++; if (cdb_out[0] !== exp_lane(0)) begin n_bad++; $display("FAIL burst_c1_l0: got %h want %h", cdb_out[0], exp_lane(0)); end
    n_cmp++; if (cdb_out[1] !== exp_lane(1)) begin n_bad++; $display("FAIL burst_c1_l1: got %h want %h", cdb_out[1], exp_lane(1)); end
    n_cmp++; if (fu_ready !== 4'b0011) begin n_bad++; $display("FAIL burst_c1_ready: got %b want 0011", fu_ready); end
    n_cmp++; if (num_pending !== 3'd4) begin n_bad++; $display("FAIL burst_c1_pending: got %0d want 4", num_pending); end
    tick();
    n_cmp++; if (cdb_out[0] !== exp_lane(2)) begin n_bad++; $display("FAIL burst_c2_l0: got %h want %h", cdb_out[0], exp_lane(2)); end
    n_cmp++; if (cdb_out[1] !== exp_lane(3)) begin n_bad++; $display("FAIL burst_c2_l1: got %h want %h", cdb_out[1], exp_lane(3)); end
    n_cmp++; if (num_pending !== 3'd2) begin n_bad++; $display("FAIL burst_c2_pending: got %0d want 2", num_pending); end
    tick();
    n_cmp++; if (cdb_out[0].valid !== 1'b0) begin n_bad++; $display("FAIL burst_c3_l0_valid: got %b want 0", cdb_out[0].valid); end
    n_cmp++; if (num_pending !== 3'd0) begin n_bad++; $display("FAIL burst_c3_pending: got %0d want 0", num_pending); end
  endtask

  task automatic test_fairness();
    do_reset();
    fu_valid = 4'b1111;
    tick();
    for (int c = 1; c <= 6; c++) begin
      int a;
      logic [NR-1:0] rdy;
      a   = (c % 2 == 1) ? 0 : 2;
      rdy = (c % 2 == 1) ? 4'b0011 : 4'b1100;
      #1;
      n_cmp++; if (cdb_out[0] !== exp_lane(a)) begin n_bad++; $display("FAIL fair_c%0d_l0: got %h want %h", c, cdb_out[0], exp_lane(a)); end
      n_cmp++; if (cdb_out[1] !== exp_lane(a + 1)) begin n_bad++; $display("FAIL fair_c%0d_l1: got %h want %h", c, cdb_out[1], exp_lane(a + 1)); end
      n_cmp++; if (fu_ready !== rdy) begin n_bad++; $display("FAIL fair_c%0d_ready: got %b want %b", c, fu_ready, rdy); end
      n_cmp++; if (num_pending !== 3'd4) begin n_bad++; $display("FAIL fair_c%0d_pending: got %0d want 4", c, num_pending); end
      tick();
    end
    set_idle();
    tick(); tick(); tick();
  endtask

  task automatic test_squash();
    do_reset();
    fu_valid = 4'b1111;
    fu_result[2] = mk(2, 4'b0010);
    tick();
    fu_valid = 4'b0100;
    br_task  = SQUASH;
    br_id    = 4'b0010;
    #1;
    n_cmp++; if (cdb_out[0] !== exp_lane(0)) begin n_bad++; $display("FAIL squash_l0: got %h want %h", cdb_out[0], exp_lane(0)); end
    n_cmp++; if (cdb_out[1] !== exp_lane(1)) begin n_bad++; $display("FAIL squash_l1: got %h want %h", cdb_out[1], exp_lane(1)); end
    n_cmp++; if (fu_ready !== 4'b0111) begin n_bad++; $display("FAIL squash_ready: got %b want 0111", fu_ready); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (cdb_out[0] !== exp_lane(3)) begin n_bad++; $display("FAIL squash_after_l0: got %h want %h", cdb_out[0], exp_lane(3)); end
    n_cmp++; if (cdb_out[1] !== cdb_packet_t'(0)) begin n_bad++; $display("FAIL squash_after_l1: got %h want 0", cdb_out[1]); end
    n_cmp++; if (num_pending !== 3'd1) begin n_bad++; $display("FAIL squash_after_pending: got %0d want 1", num_pending); end
    tick();
    n_cmp++; if (num_pending !== 3'd0) begin n_bad++; $display("FAIL squash_drain_pending: got %0d want 0", num_pending); end
  endtask

  task automatic test_clear();
    do_reset();
    fu_valid = 4'b0011;
    tick();
    fu_valid = 4'b1111;
    fu_result[1] = mk(1, 4'b0110);
    tick();
    set_idle();
    br_task = CLEAR;
    br_id   = 4'b0010;
    #1;
    n_cmp++; if (cdb_out[0] !== exp_lane(2)) begin n_bad++; $display("FAIL clear_l0: got %h want %h", cdb_out[0], exp_lane(2)); end
    n_cmp++; if (cdb_out[1] !== exp_lane(3)) begin n_bad++; $display("FAIL clear_l1: got %h want %h", cdb_out[1], exp_lane(3)); end
    n_cmp++; if (fu_ready !== 4'b1100) begin n_bad++; $display("FAIL clear_ready: got %b want 1100", fu_ready); end
    tick();
    br_task = SQUASH;
    br_id   = 4'b0010;
    #1;
    n_cmp++; if (cdb_out[0] !== exp_lane(0)) begin n_bad++; $display("FAIL clear_sq_l0: got %h want %h", cdb_out[0], exp_lane(0)); end
    n_cmp++; if (cdb_out[1] !== exp_lane(1)) begin n_bad++; $display("FAIL clear_sq_l1: got %h want %h", cdb_out[1], exp_lane(1)); end
    n_cmp++; if (num_pending !== 3'd2) begin n_bad++; $display("FAIL clear_sq_pending: got %0d want 2", num_pending); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (num_pending !== 3'd0) begin n_bad++; $display("FAIL clear_drain_pending: got %0d want 0", num_pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fu_valid = 4'b0011;
    tick();
    fu_valid = 4'b0111;
    tick();
    set_idle();
    #1;
    n_cmp++; if (num_pending !== 3'd3) begin n_bad++; $display("FAIL midrst_pre_pending: got %0d want 3", num_pending); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (num_pending !== 3'd0) begin n_bad++; $display("FAIL midrst_pending: got %0d want 0", num_pending); end
    for (int l = 0; l < N; l++) begin
      n_cmp++;
      if (cdb_out[l].valid !== 1'b0) begin n_bad++; $display("FAIL midrst_lane%0d_valid: got %b want 0", l, cdb_out[l].valid); end
    end
    fu_valid = 4'b1111;
    tick();
    set_idle();
    #1;
    n_cmp++; if (cdb_out[0] !== exp_lane(0)) begin n_bad++; $display("FAIL midrst_first_l0: got %h want %h", cdb_out[0], exp_lane(0)); end
    n_cmp++; if (cdb_out[1] !== exp_lane(1)) begin n_bad++; $display("FAIL midrst_first_l1: got %h want %h", cdb_out[1], exp_lane(1)); end
    tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      int r;
      fu_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        fu_result[i].reg_idx = REG_IDX_W'($urandom);
        fu_result[i].value   = $urandom;
        fu_result[i].b_mask  = ($urandom_range(0, 2) == 0) ? br_mask_t'($urandom) : br_mask_t'(0);
      end
      r       = $urandom_range(0, 9);
      br_task = (r < 6) ? NOTHING : (r < 8) ? CLEAR : SQUASH;
      br_id   = br_mask_t'(1 << $urandom_range(0, BR_W - 1));
      #1;
      model_predict();
      for (int l = 0; l < N; l++) begin
        n_cmp++;
        if (cdb_out[l] !== e_lanes[l]) begin
          n_bad++; $display("FAIL rand_c%0d_lane%0d: got %h want %h", c, l, cdb_out[l], e_lanes[l]);
        end
      end
      n_cmp++;
      if (fu_ready !== e_ready) begin n_bad++; $display("FAIL rand_c%0d_ready: got %b want %b", c, fu_ready, e_ready); end
      n_cmp++;
      if (int'(num_pending) !== e_pending) begin n_bad++; $display("FAIL rand_c%0d_pending: got %0d want %0d", c, num_pending, e_pending); end
      @(posedge clock);
      model_commit();
      #1;
    end
    set_idle();
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    test_reset();
    test_burst();
    test_fairness();
    test_squash();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
